// File: rtl/sram_sp_be_ctrl.sv
// Single-port byte-enable SRAM controller: power-up/requested clear sweep, valid/ready
// request port, in-order response FIFO, optional output register on array reads.
module sram_sp_be_ctrl #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 2**ADDR_WIDTH,
    parameter int                    OUT_REG    = 0,
    parameter int                    RSP_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_ni,
    input  logic                    init_i,
    output logic                    init_busy_o,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_we_o,
    output logic                    rsp_err_o
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PW     = $clog2(RSP_DEPTH);
    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] NW   = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST = NW - 1'b1;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   sweep_addr;
    logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    s1_valid, s1_we, s1_err, s1_rd;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic                    out_valid, out_we, out_err;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [1:0]              inflight;
    logic [CW-1:0]           fifo_count;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]   fifo_data [RSP_DEPTH];
    logic                    fifo_we   [RSP_DEPTH];
    logic                    fifo_err  [RSP_DEPTH];
    logic [CW:0]             occupancy;
    logic                    accept, in_range, sweep_en, wr_en, rd_en, push, pop;
    logic [IW-1:0]           req_idx, sweep_idx;

    // Handshakes: a request transfers on a rising edge where req_valid_i && req_ready_o;
    // a response transfers where rsp_valid_o && rsp_ready_i. req_ready_o depends only on
    // registered state and init_i, never on req_valid_i or rsp_ready_i.
    assign occupancy   = {1'b0, fifo_count} + (CW + 1)'(inflight);
    assign req_ready_o = (state_q == ST_RUN) && !init_i && (occupancy < (CW + 1)'(RSP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign in_range    = ({1'b0, req_addr_i} < NW);
    assign req_idx     = req_addr_i[IW-1:0];
    assign sweep_idx   = sweep_addr[IW-1:0];
    assign sweep_en    = (state_q == ST_INIT);
    assign wr_en       = accept && req_we_i && in_range;
    assign rd_en       = accept && !req_we_i && in_range;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            sweep_addr  <= '0;
            init_busy_o <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if ({1'b0, sweep_addr} == LAST) begin
                        state_q     <= ST_RUN;
                        init_busy_o <= 1'b0;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_i) begin
                        state_q     <= ST_DRAIN;
                        init_busy_o <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Queued responses may still be waiting; only the array pipeline must be empty.
                    if (inflight == 2'd0) begin
                        state_q    <= ST_INIT;
                        sweep_addr <= '0;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[sweep_idx] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (req_be_i[b]) mem[req_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
        end
        if (rd_en) mem_rdata <= mem[req_idx];
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_err   <= 1'b0;
            s1_rd    <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_we    <= req_we_i;
            s1_err   <= !in_range;
            s1_rd    <= rd_en;
        end
    end

    assign s1_data = s1_rd ? mem_rdata : '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid, s2_we, s2_err;
        logic [DATA_WIDTH-1:0] s2_data;
        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_valid <= 1'b0;
                s2_we    <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_we    <= s1_we;
                s2_err   <= s1_err;
                s2_data  <= s1_data;
            end
        end
        assign out_valid = s2_valid;
        assign out_we    = s2_we;
        assign out_err   = s2_err;
        assign out_data  = s2_data;
        assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};
    end else begin : g_no_out_reg
        assign out_valid = s1_valid;
        assign out_we    = s1_we;
        assign out_err   = s1_err;
        assign out_data  = s1_data;
        assign inflight  = {1'b0, s1_valid};
    end

    assign push = out_valid;
    assign pop  = rsp_valid_o && rsp_ready_i;

    // Acceptance reserves a FIFO slot, so a push can never land on the held head entry.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= out_data;
            fifo_we[wr_ptr]   <= out_we;
            fifo_err[wr_ptr]  <= out_err;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_data[rd_ptr] : '0;
    assign rsp_we_o    = rsp_valid_o && fifo_we[rd_ptr];
    assign rsp_err_o   = rsp_valid_o && fifo_err[rd_ptr];

endmodule
